// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the block-RAM arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  typedef logic client_id_t;

  localparam int DEF_MIN_LAT = 9;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pref,
  output logic       valid,
  output client_id_t winner
);

  // A lone requester always wins; pref only breaks ties.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? pref : req[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client round-robin sequencer for the block-RAM port
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int BLK_W   = 256,
  parameter int MIN_LAT = DEF_MIN_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [BLK_W-1:0]  c0_wdata,
  output logic              c0_ack,
  output logic              c0_err,
  output logic [BLK_W-1:0]  c0_rdata,
  input  logic              c1_req,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [BLK_W-1:0]  c1_wdata,
  output logic              c1_ack,
  output logic              c1_err,
  output logic [BLK_W-1:0]  c1_rdata,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic              mem_rdy,
  input  logic [BLK_W-1:0]  mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e       state;
  logic             pref;
  client_id_t       gnt;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid;
  client_id_t       pick;
  logic             accept;
  logic             expire;

  rr_arb2 u_pick (
    .req    ({c1_req, c0_req}),
    .pref   (pref),
    .valid  (pick_valid),
    .winner (pick)
  );

  // mem_rdy is only trusted once the port has had MIN_LAT cycles to respond.
  assign accept = (state == BUSY) && (cnt >= CNT_MIN) && mem_rdy;
  assign expire = (state == BUSY) && (cnt == CNT_MAX) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pref      <= 1'b0;
      gnt       <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c0_ack    <= 1'b0;
      c0_err    <= 1'b0;
      c0_rdata  <= '0;
      c1_ack    <= 1'b0;
      c1_err    <= 1'b0;
      c1_rdata  <= '0;
    end else begin
      c0_ack <= 1'b0;
      c0_err <= 1'b0;
      c1_ack <= 1'b0;
      c1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= BUSY;
            gnt       <= pick;
            pref      <= ~pick;
            cnt       <= '0;
            mem_en    <= 1'b1;
            mem_write <= pick ? c1_write : c0_write;
            mem_addr  <= pick ? c1_addr  : c0_addr;
            mem_wdata <= pick ? c1_wdata : c0_wdata;
          end
        end
        BUSY: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (accept || expire) begin
            state  <= GAP;
            mem_en <= 1'b0;
            if (gnt) begin
              c1_ack <= 1'b1;
              c1_err <= expire;
              if (accept && !mem_write) c1_rdata <= mem_rdata;
            end else begin
              c0_ack <= 1'b1;
              c0_err <= expire;
              if (accept && !mem_write) c0_rdata <= mem_rdata;
            end
          end
        end
        // GAP holds mem_en low one extra cycle so the port sees a 2-cycle gap.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-client arbiter and sequencer for the block-RAM backing store behind the caches. Client 0 (D-cache refill/writeback) and client 1 (I-cache refill) issue 256-bit block requests. The arbiter grants one at a time round-robin and drives the single RAM port. It enforces the port's enable-gap and minimum-latency rules, returns read blocks and ack pulses, and aborts hung transfers with a timeout.

## Interface
- ADDR_W, 11: block address width
- BLK_W, 256: block data width
- MIN_LAT, 9: BUSY cycles before `mem_rdy` is trusted
- TIMEOUT, 64: BUSY cycles before abort (TIMEOUT > MIN_LAT)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cN_req  in  1  client N request (N = 0, 1); held with fields stable until ack
- cN_write  in  1  client N: 1 = write block, 0 = read block
- cN_addr  in  ADDR_W  client N block address
- cN_wdata  in  BLK_W  client N write block
- cN_ack  out  1  client N one-cycle completion pulse
- cN_err  out  1  client N timeout flag, valid with cN_ack
- cN_rdata  out  BLK_W  client N last read block, registered
- mem_en  out  1  RAM port enable
- mem_write  out  1  RAM write select
- mem_addr  out  ADDR_W  RAM block address
- mem_wdata  out  BLK_W  RAM write block
- mem_rdy  in  1  RAM completion indication
- mem_rdata  in  BLK_W  RAM read block

## Operation
- FSM states:
  - IDLE → BUSY on any cN_req.
  - BUSY → GAP on accepted completion or on timeout.
  - GAP → IDLE unconditionally.
- Grant in IDLE:
  - Only one client requesting: that client wins.
  - Both requesting: the client indicated by `pref` wins.
  - `pref` then flips to the loser. Reset value of `pref` = 0.
- At grant, the winner's write/addr/wdata are latched into mem_write/mem_addr/mem_wdata, and `gnt` records the client id. Outputs are held through BUSY.
- BUSY counter `cnt` (width clog2(TIMEOUT+1)):
  - Cleared on entry to BUSY, increments each BUSY cycle.
  - Saturates at TIMEOUT.
- Completion accepted when BUSY, cnt ≥ MIN_LAT, and mem_rdy = 1. On acceptance:
  - If read: cN_rdata[gnt] <= mem_rdata.
  - cN_ack[gnt] pulses with cN_err = 0.
- Timeout fires when BUSY and cnt = TIMEOUT without acceptance:
  - cN_ack[gnt] pulses with cN_err = 1.
  - cN_rdata is unchanged.
- mem_rdy is ignored outside BUSY and while cnt < MIN_LAT.
- Request deasserted while granted: the transfer still runs to completion and the ack still pulses. Deasserted while ungranted: simply not considered.
- The granted client must drop cN_req in the cycle after its ack. Otherwise it is re-arbitrated as a new request.

## Timing
- All outputs are registered.
- Reset values: mem_en = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, cN_ack = 0, cN_err = 0, cN_rdata = 0, state = IDLE, pref = 0, cnt = 0.
- Reset mid-transfer: mem_en drops asynchronously and no ack is issued.
- Cycle-level sequence:
  - Req sampled in IDLE at edge T → mem_en = 1 from T+1.
  - Acceptance sampled at edge T+k → cN_ack = 1 and mem_en = 0 during T+k+1 (GAP).
  - T+k+2 is IDLE again; the next grant's mem_en rises at T+k+3 at the earliest.
- mem_en is low for at least 2 cycles between transfers; the RAM port restarts its word counter on enable low.
- Minimum request-to-ack latency is MIN_LAT+2 cycles; maximum is TIMEOUT+2.
- cN_ack is never high for both clients in the same cycle and is never high for two consecutive cycles.

## Structure
- Shared package `ram_arb_pkg`:
  - state enum (IDLE/BUSY/GAP)
  - client id type
  - default MIN_LAT / TIMEOUT constants
- One sub-module, `rr_arb2`: combinational 2-way round-robin pick from req[1:0] and pref. The pref update stays in the parent.

## Test plan
- Single read: c0 read addr 11'h005, mem_rdy = 1 at cnt = 9 with mem_rdata = 256'hA5… → c0_ack at request+11 cycles, c0_rdata = 256'hA5…, c0_err = 0.
- Early rdy: mem_rdy held 1 from the first BUSY cycle → acceptance still occurs at cnt = MIN_LAT, not earlier.
- Contention: both clients request from reset → c0 served first, then c1. After c1, c0 re-requests simultaneously with c1 → c0 wins (pref = 0 after c1's grant). mem_en gap is ≥ 2 cycles each time.
- Write: c1 write addr 11'h7FF, data 256'h1234… → mem_write = 1, mem_wdata matches, c1_rdata unchanged after ack.
- Timeout: mem_rdy stuck 0 → c0_ack with c0_err = 1 at request+66 cycles, mem_en drops, arbiter returns to IDLE.
- Reset mid-BUSY: assert rst_n = 0 at cnt = 4 → mem_en = 0 immediately, no ack, all outputs at reset values.
